// File: rtl/rom_switch_ctrl_pkg.sv
// Shared types and default timing for the runtime ROM selector.
// The optional ROM_SWITCH_REPEAT_EN macro (auto-repeat) is handled in the top module.
package rom_switch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  localparam int DEF_IDX_W           = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 131072;
  localparam int DEF_HOLD_CYCLES     = 1024;
  localparam int DEF_WAIT_LOW_MAX    = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_switch_ctrl_if.sv
// main_mem side of the ROM selector: reload request, slot index, load status, NES reset hold.
interface rom_switch_ctrl_if
  import rom_switch_ctrl_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
);
  logic             load_done;
  logic             reload;
  logic [IDX_W-1:0] rom_index;
  logic             nes_reset_hold;
  logic             busy;

  modport master (
    input  load_done,
    output reload,
    output rom_index,
    output nes_reset_hold,
    output busy
  );

  modport slave (
    output load_done,
    input  reload,
    input  rom_index,
    input  nes_reset_hold,
    input  busy
  );
endinterface

// File: rtl/rom_switch_ctrl_btn_debounce.sv
// One raw active-low button: 2-FF synchroniser followed by a stable-count debouncer.
module btn_debounce
  import rom_switch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic stable
);
  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Any disagreement with the accepted level must persist DEBOUNCE_CYCLES cycles to be taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign stable = r_stable;

endmodule

// File: rtl/rom_switch_ctrl.sv
// Runtime ROM selector: menu+L/R combo steps the ROM index, sequences the main_mem reload
// and holds the NES core in reset until the new image settles. ROM_SWITCH_REPEAT_EN adds auto-repeat.
module rom_switch_ctrl
  import rom_switch_ctrl_pkg::*;
#(
  parameter int IDX_W           = DEF_IDX_W,
  parameter int INIT_INDEX      = 0,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int WAIT_LOW_MAX    = DEF_WAIT_LOW_MAX
`ifdef ROM_SWITCH_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 4194304
`endif
)(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                btn_m,
  input  logic                btn_l,
  input  logic                btn_r,
  rom_switch_ctrl_if.master   mem
);
  localparam int             WLW       = cnt_width(WAIT_LOW_MAX);
  localparam int             HW        = cnt_width(HOLD_CYCLES);
  localparam logic [WLW-1:0] WL_LAST   = WLW'(WAIT_LOW_MAX - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic             w_stable_m;
  logic             w_stable_l;
  logic             w_stable_r;
  logic             w_press_l;
  logic             w_press_r;
  logic             w_fire_l;
  logic             w_fire_r;
  logic             r_l_prev;
  logic             r_r_prev;

  state_t           r_state;
  logic             r_reload;
  logic             r_hold;
  logic             r_busy;
  logic [IDX_W-1:0] r_rom_index;
  logic [WLW-1:0]   r_wl_cnt;
  logic [HW-1:0]    r_hold_cnt;

  // Modulo-2**IDX_W step; natural wrap of the IDX_W-bit sum gives 0-1 -> max and max+1 -> 0.
  function automatic logic [IDX_W-1:0] step_index(input logic [IDX_W-1:0] idx, input logic down);
    return down ? (idx - IDX_W'(1)) : (idx + IDX_W'(1));
  endfunction

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_m (
    .clock (clock), .reset_n (reset_n), .raw (btn_m), .stable (w_stable_m)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .clock (clock), .reset_n (reset_n), .raw (btn_l), .stable (w_stable_l)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .clock (clock), .reset_n (reset_n), .raw (btn_r), .stable (w_stable_r)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_l_prev <= 1'b1;
      r_r_prev <= 1'b1;
    end else begin
      r_l_prev <= w_stable_l;
      r_r_prev <= w_stable_r;
    end
  end

  // A press counts only while the menu button is already held down.
  assign w_press_l = r_l_prev & ~w_stable_l & ~w_stable_m;
  assign w_press_r = r_r_prev & ~w_stable_r & ~w_stable_m;

`ifdef ROM_SWITCH_REPEAT_EN
  localparam int            RW       = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rep_l;
  logic [RW-1:0] r_rep_r;

  // Counters restart at the press and wrap each time a repeat fires.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rep_l <= '0;
      r_rep_r <= '0;
    end else begin
      if (w_stable_m || w_stable_l || w_press_l || (r_rep_l == REP_LAST)) r_rep_l <= '0;
      else                                                              r_rep_l <= r_rep_l + RW'(1);
      if (w_stable_m || w_stable_r || w_press_r || (r_rep_r == REP_LAST)) r_rep_r <= '0;
      else                                                              r_rep_r <= r_rep_r + RW'(1);
    end
  end

  assign w_fire_l = w_press_l | (~w_stable_m & ~w_stable_l & (r_rep_l == REP_LAST));
  assign w_fire_r = w_press_r | (~w_stable_m & ~w_stable_r & (r_rep_r == REP_LAST));
`else
  assign w_fire_l = w_press_l;
  assign w_fire_r = w_press_r;
`endif

  // Outputs are set for the state being entered, so every output is a plain register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_WAIT_DONE;
      r_reload    <= 1'b0;
      r_rom_index <= IDX_W'(INIT_INDEX);
      r_hold      <= 1'b1;
      r_busy      <= 1'b1;
      r_wl_cnt    <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_reload <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fire_l ^ w_fire_r) begin
            r_rom_index <= step_index(r_rom_index, w_fire_l);
            r_state     <= ST_REQ;
            r_reload    <= 1'b1;
            r_hold      <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_REQ: begin
          r_wl_cnt <= '0;
          r_state  <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          // main_mem may never drop load_done; the timeout keeps us from stalling here.
          if (!mem.load_done || (r_wl_cnt == WL_LAST)) r_state  <= ST_WAIT_DONE;
          else                                          r_wl_cnt <= r_wl_cnt + WLW'(1);
        end
        ST_WAIT_DONE: begin
          if (mem.load_done) begin
            r_hold_cnt <= '0;
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!mem.load_done) begin
            r_hold_cnt <= '0;
            r_state    <= ST_WAIT_DONE;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state <= ST_IDLE;
            r_hold  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        default: begin
          r_state <= ST_WAIT_DONE;
          r_hold  <= 1'b1;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign mem.reload         = r_reload;
  assign mem.rom_index      = r_rom_index;
  assign mem.nes_reset_hold = r_hold;
  assign mem.busy           = r_busy;

endmodule
